// File: rtl/key_cmd_if.sv
// key_cmd_if -- bus between the PS/2 byte source / display panel and
// key_cmd_ctrl.
//
// Signals:
//   scancode[7:0], valid         : keyboard byte stream (valid is a 1-cycle strobe)
//   cmd_valid, cmd_ready         : command FIFO head handshake
//   cmd_code[2:0], cmd_x, cmd_y  : head command and the cursor after it
//   cursor_x, cursor_y           : live cursor position
//   drop                         : a decoded command was lost to a full FIFO
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_valid never depends on cmd_ready, and the head
// fields hold steady while cmd_valid=1 and cmd_ready=0. cmd_ready has no
// effect while cmd_valid=0.
//
// Modports: slave = key_cmd_ctrl side, master = keyboard/panel side.
interface key_cmd_if;
  logic [7:0] scancode;
  logic       valid;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [3:0] cursor_x;
  logic [3:0] cursor_y;
  logic       drop;

  modport slave (
    input  scancode, valid, cmd_ready,
    output cmd_valid, cmd_code, cmd_x, cmd_y, cursor_x, cursor_y, drop
  );

  modport master (
    output scancode, valid, cmd_ready,
    input  cmd_valid, cmd_code, cmd_x, cmd_y, cursor_x, cursor_y, drop
  );
endinterface

// File: rtl/key_cmd_ctrl.sv
// key_cmd_ctrl -- decodes PS/2 scancodes into cursor commands, moves a
// wrap-around cursor on a GRID_W x GRID_H grid and queues
// {code, new x, new y} in a small command FIFO for the display panel.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   kb         : key_cmd_if.slave (byte input, command FIFO head, cursor, drop)
//   dbg_state  : decoder FSM state (0 IDLE, 1 BRK, 2 EXT, 3 EXT_BRK)
//
// Optional feature: define KEY_REPEAT_FILTER_EN to suppress typematic
// repeats. A held mask (one bit per command key) is set on make and cleared
// by the matching break; a make of a held key produces nothing.
module key_cmd_ctrl #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  key_cmd_if.slave   kb,
  output logic [1:0] dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  X_MAX   = 4'(GRID_W - 1);
  localparam logic [3:0]  Y_MAX   = 4'(GRID_H - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [2:0] CMD_UP     = 3'd0;
  localparam logic [2:0] CMD_DOWN   = 3'd1;
  localparam logic [2:0] CMD_LEFT   = 3'd2;
  localparam logic [2:0] CMD_RIGHT  = 3'd3;
  localparam logic [2:0] CMD_SELECT = 3'd4;
  localparam logic [2:0] CMD_CLEAR  = 3'd5;

  logic [1:0] state, state_nxt;
  logic       key_known;
  logic [2:0] key_code;
  logic       make_hit;
  logic       cmd_fire;

  logic [3:0] cur_x, cur_y, x_nxt, y_nxt;

  logic [2:0]    mem_code [FIFO_DEPTH];
  logic [3:0]    mem_x    [FIFO_DEPTH];
  logic [3:0]    mem_y    [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          not_empty, full, pop, push;
  logic          drop_q;

  // Map the current byte to a key. Extended keys are only recognised after
  // E0 (EXT / EXT_BRK), plain keys only without it (IDLE / BRK). The same
  // lookup serves both makes and breaks.
  always_comb begin
    key_known = 1'b0;
    key_code  = CMD_UP;
    if (state == ST_EXT || state == ST_EXT_BRK) begin
      case (kb.scancode)
        8'h75:   begin key_known = 1'b1; key_code = CMD_UP;    end
        8'h72:   begin key_known = 1'b1; key_code = CMD_DOWN;  end
        8'h6B:   begin key_known = 1'b1; key_code = CMD_LEFT;  end
        8'h74:   begin key_known = 1'b1; key_code = CMD_RIGHT; end
        default: ;
      endcase
    end else begin
      case (kb.scancode)
        8'h5A:   begin key_known = 1'b1; key_code = CMD_SELECT; end
        8'h76:   begin key_known = 1'b1; key_code = CMD_CLEAR;  end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (kb.valid) begin
      case (state)
        ST_IDLE: begin
          if (kb.scancode == 8'hF0)      state_nxt = ST_BRK;
          else if (kb.scancode == 8'hE0) state_nxt = ST_EXT;
        end
        ST_EXT: begin
          if (kb.scancode == 8'hF0)      state_nxt = ST_EXT_BRK;
          else if (kb.scancode == 8'hE0) state_nxt = ST_EXT;
          else                           state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  assign dbg_state = state;

  // A make is a known key byte seen in IDLE or EXT; breaks never fire.
  assign make_hit = kb.valid && key_known && (state == ST_IDLE || state == ST_EXT);

`ifdef KEY_REPEAT_FILTER_EN
  logic [5:0] held;
  logic       brk_hit;

  assign brk_hit  = kb.valid && key_known && (state == ST_BRK || state == ST_EXT_BRK);
  assign cmd_fire = make_hit && !held[key_code];

  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
    end else begin
      if (make_hit) held[key_code] <= 1'b1;
      if (brk_hit)  held[key_code] <= 1'b0;
    end
  end
`else
  assign cmd_fire = make_hit;
`endif

  // Cursor after the decoded command, wrapping on each axis.
  always_comb begin
    x_nxt = cur_x;
    y_nxt = cur_y;
    case (key_code)
      CMD_UP:    y_nxt = (cur_y == 4'd0)  ? Y_MAX : cur_y - 4'd1;
      CMD_DOWN:  y_nxt = (cur_y == Y_MAX) ? 4'd0  : cur_y + 4'd1;
      CMD_LEFT:  x_nxt = (cur_x == 4'd0)  ? X_MAX : cur_x - 4'd1;
      CMD_RIGHT: x_nxt = (cur_x == X_MAX) ? 4'd0  : cur_x + 4'd1;
      CMD_CLEAR: begin x_nxt = 4'd0; y_nxt = 4'd0; end
      default:   ;
    endcase
  end

  // The cursor moves on every decoded command, even one the FIFO drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x <= 4'd0;
      cur_y <= 4'd0;
    end else if (cmd_fire) begin
      cur_x <= x_nxt;
      cur_y <= y_nxt;
    end
  end

  assign kb.cursor_x = cur_x;
  assign kb.cursor_y = cur_y;

  // Command FIFO. A pop in the same cycle frees the slot, so a full FIFO
  // still accepts the push; the slot written then is the one being popped.
  assign not_empty = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = not_empty && kb.cmd_ready;
  assign push      = cmd_fire && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wr_ptr] <= key_code;
      mem_x[wr_ptr]    <= x_nxt;
      mem_y[wr_ptr]    <= y_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      drop_q <= cmd_fire && full && !pop;
    end
  end

  assign kb.drop      = drop_q;
  assign kb.cmd_valid = not_empty;
  // Head fields read as zero while empty so reset leaves them at 0.
  assign kb.cmd_code  = not_empty ? mem_code[rd_ptr] : 3'd0;
  assign kb.cmd_x     = not_empty ? mem_x[rd_ptr]    : 4'd0;
  assign kb.cmd_y     = not_empty ? mem_y[rd_ptr]    : 4'd0;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
module tb_key_cmd_ctrl;
  localparam int GRID_W     = 16;
  localparam int GRID_H     = 12;
  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  key_cmd_if bus ();

  key_cmd_ctrl #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .kb(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [10:0] exp_q[$];     // {code[2:0], x[3:0], y[3:0]}
  int          mx, my;
  bit          m_ext, m_brk;
  bit   [5:0]  m_held;
  bit          exp_drop;
  int          n_checks, n_errors, drop_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Key meaning of a byte: extended keys need a preceding E0.
  function automatic int key_of(input bit ext, input logic [7:0] b);
    if (ext) begin
      case (b)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        default: return -1;
      endcase
    end
    case (b)
      8'h5A: return 4;
      8'h76: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mx = 0; my = 0;
    m_ext = 0; m_brk = 0; m_held = '0;
    exp_drop = 0;
  endtask

  // One clock edge of behaviour, computed from the pre-edge inputs.
  task automatic model_step(input bit v, input logic [7:0] sc, input bit rdy, input bit r);
    int  k;
    int  cmd;
    bit  do_pop;
    if (r) begin
      model_reset();
      return;
    end
    do_pop   = (exp_q.size() != 0) && rdy;
    exp_drop = 0;
    cmd      = -1;
    if (v) begin
      if (m_brk) begin
        k = key_of(m_ext, sc);
        if (k >= 0) m_held[k] = 1'b0;
        m_ext = 0; m_brk = 0;
      end else if (sc == 8'hF0) begin
        m_brk = 1;
      end else if (sc == 8'hE0) begin
        m_ext = 1;
      end else begin
        k = key_of(m_ext, sc);
        m_ext = 0;
        if (k >= 0) begin
`ifdef KEY_REPEAT_FILTER_EN
          if (!m_held[k]) cmd = k;
          m_held[k] = 1'b1;
`else
          cmd = k;
`endif
        end
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (cmd >= 0) begin
      case (cmd)
        0: my = (my + GRID_H - 1) % GRID_H;
        1: my = (my + 1) % GRID_H;
        2: mx = (mx + GRID_W - 1) % GRID_W;
        3: mx = (mx + 1) % GRID_W;
        5: begin mx = 0; my = 0; end
        default: ;
      endcase
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({3'(cmd), 4'(mx), 4'(my)});
      else exp_drop = 1;
    end
  endtask

  task automatic check_all();
    logic [10:0] h;
    check("cmd_valid", bus.cmd_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("cmd_code", bus.cmd_code, h[10:8]);
      check("cmd_x",    bus.cmd_x,    h[7:4]);
      check("cmd_y",    bus.cmd_y,    h[3:0]);
    end
    check("cursor_x", bus.cursor_x, mx);
    check("cursor_y", bus.cursor_y, my);
    check("drop",     bus.drop,     exp_drop);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input logic [7:0] sc, input bit rdy, input bit r);
    bus.valid     = v;
    bus.scancode  = sc;
    bus.cmd_ready = rdy;
    rst           = r;
    @(posedge clk);
    #1;
    model_step(v, sc, rdy, r);
    check_all();
    if (bus.drop) drop_seen++;
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cycle(1'b1, b, rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pick_tab [10];
  int         n;

  initial begin
    n_checks = 0; n_errors = 0; drop_seen = 0;
    bus.valid = 0; bus.scancode = 0; bus.cmd_ready = 0; rst = 1;
    model_reset();
    pick_tab = '{8'hE0, 8'hF0, 8'h5A, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'h00};

    // Reset state
    do_reset();
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cursor_x",  bus.cursor_x,  0);
    check("rst_state",     dbg_state,     0);

    // E0,74 -> RIGHT x=1, visible right after the 74 edge
    send(8'hE0, 0);
    check("r031_pre_valid", bus.cmd_valid, 0);
    send(8'h74, 0);
    check("r031_valid", bus.cmd_valid, 1);
    check("r031_code",  bus.cmd_code,  3);
    check("r031_x",     bus.cmd_x,     1);
    check("r031_y",     bus.cmd_y,     0);
    idle(1);
    check("r031_popped", bus.cmd_valid, 0);

    // Wrap-around on both axes
    do_reset();
    send(8'hE0, 0); send(8'h6B, 0);
    check("r032_left_code", bus.cmd_code, 2);
    check("r032_left_x",    bus.cmd_x,    15);
    do_reset();
    send(8'hE0, 1); send(8'h75, 1);
    check("r032_up_y", bus.cmd_y, 11);
    send(8'hE0, 1); send(8'h72, 1);
    check("r032_down_code", bus.cmd_code, 1);
    check("r032_down_y",    bus.cmd_y,    0);
    idle(1);

    // Overflow: six RIGHT presses (each released) with the panel stalled
    do_reset();
    drop_seen = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'hE0, 0); send(8'h74, 0);
      send(8'hE0, 0); send(8'hF0, 0); send(8'h74, 0);
    end
    check("r033_drops",    drop_seen,    2);
    check("r033_cursor_x", bus.cursor_x, 6);
    for (int i = 1; i <= 4; i++) begin
      check("r033_pop_x", bus.cmd_x, i);
      idle(1);
    end
    check("r033_empty", bus.cmd_valid, 0);

    // Break codes produce nothing; CLEAR zeroes the cursor
    do_reset();
    send(8'hE0, 1); send(8'h74, 1);
    send(8'hF0, 1); send(8'h5A, 1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
    check("r034_state", dbg_state,     0);
    check("r034_empty", bus.cmd_valid, 0);
    send(8'h76, 0);
    check("r034_clear_code", bus.cmd_code, 5);
    check("r034_clear_x",    bus.cmd_x,    0);
    check("r034_clear_y",    bus.cmd_y,    0);

    // Reset mid-sequence discards the E0 prefix
    do_reset();
    send(8'hE0, 0);
    cycle(1'b1, 8'h75, 1'b0, 1'b1);
    send(8'h75, 0);
    check("r035_none", bus.cmd_valid, 0);
    idle(0);
    check("r035_none2", bus.cmd_valid, 0);

    // Typematic repeat
    do_reset();
    send(8'h5A, 0); send(8'h5A, 0); send(8'hF0, 0); send(8'h5A, 0); send(8'h5A, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.cmd_valid) n++;
      idle(1);
    end
`ifdef KEY_REPEAT_FILTER_EN
    check("r036_selects", n, 2);
`else
    check("r036_selects", n, 3);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      bit         v, rdy, r;
      b   = pick_tab[$urandom_range(0, 9)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      v   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 1) == 1);
      r   = ($urandom_range(0, 199) == 0);
      cycle(v, b, rdy, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
